vr_commit_engine: RTL and testbench
===================================

Name: vr_commit_engine

Overview:
- Sequences commit processing for the replica's log-entry header store.
- On each Commit request (view, opnum) it walks entries last_commit+1 .. opnum. For each entry it reads the header, checks it, rewrites log_entry_state to LOG_STATE_COMMITED, and advances last_commit.
- Sits between the Commit message parser and the log header RAM. It is the sole owner of last_commit.

Parameters:
- INT_W, 64, op/view width (package constant).
- LOG_DEPTH_W, 10, log header RAM address width (package constant; entry address = opnum[LOG_DEPTH_W-1:0]).
- HDR_W, LOG_ENTRY_HDR_W (320), header RAM data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- setup_val  in  1  load initial last_commit (from SetupBeehive)
- setup_last_commit  in  INT_W  initial value
- curr_view  in  INT_W  replica's current view
- cmt_req_val  in  1  commit request valid
- cmt_req_view  in  INT_W  view of the commit
- cmt_req_opnum  in  INT_W  op number of the commit
- cmt_req_rdy  out  1  ready for a request
- hdr_rd_req_val  out  1  header read request valid
- hdr_rd_req_addr  out  LOG_DEPTH_W  read address
- hdr_rd_req_rdy  in  1  read request accepted
- hdr_rd_resp_val  in  1  read data valid
- hdr_rd_resp_data  in  HDR_W  log_entry_hdr read back
- hdr_rd_resp_rdy  out  1  ready for read data
- hdr_wr_req_val  out  1  header write valid
- hdr_wr_req_addr  out  LOG_DEPTH_W  write address
- hdr_wr_req_data  out  HDR_W  header to write
- hdr_wr_req_rdy  in  1  write accepted
- cmt_done_val  out  1  completion record valid
- cmt_done_count  out  INT_W  entries committed by this request
- cmt_done_status  out  2  0=OK, 1=STALE, 2=GAP, 3=RANGE
- cmt_done_rdy  in  1  completion consumed
- last_commit  out  INT_W  highest committed op number

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: state IDLE; all _val outputs 0; cmt_req_rdy 0 during reset, 1 in IDLE; last_commit 0; count 0.
- A reset asserted mid-walk abandons the walk. Entries already written stay committed.
- Handshakes: val/rdy. A transfer occurs on a cycle with val & rdy. Payload is held stable while val=1 and rdy=0.
- setup_val is honoured only in IDLE and takes priority over cmt_req_val in the same cycle. In that case last_commit <= setup_last_commit and the request is not accepted.
- FSM states: IDLE, CHECK, RD_REQ, RD_RESP, WR, DONE.
  - IDLE: cmt_req_rdy=1. On accept, latch view, opnum and target; next = CHECK.
  - CHECK (1 cycle), evaluated in this order:
    - view != curr_view or opnum <= last_commit -> status STALE, go to DONE.
    - (opnum - last_commit) > 2^LOG_DEPTH_W -> status RANGE, go to DONE. Unsigned INT_W subtraction; the log would alias.
    - otherwise cur = last_commit+1, go to RD_REQ.
  - RD_REQ: hdr_rd_req_val=1, addr = cur[LOG_DEPTH_W-1:0]. On handshake go to RD_RESP.
  - RD_RESP: hdr_rd_resp_rdy=1. On valid, check hdr.op_num == cur and hdr.view == view.
    - Mismatch (entry not yet prepared) -> status GAP, go to DONE.
    - Match -> go to WR.
  - WR: write the same header with log_entry_state=LOG_STATE_COMMITED and all other fields unchanged. On handshake: last_commit <= cur, count++.
    - If cur == opnum: status OK, go to DONE.
    - Else: cur++ and go to RD_REQ.
  - DONE: cmt_done_val=1. On handshake clear count and return to IDLE.
- Latency: OK commit of N entries with zero-wait memory takes 3N+2 cycles from accept to cmt_done_val.
- Address wrap: cur[LOG_DEPTH_W-1:0] wraps 1023 -> 0 naturally.
- Simultaneous events: last_commit updates in the same cycle as the write handshake and is visible on the next cycle.
- The engine never issues a read and a write concurrently; at most one memory transaction is outstanding.

Optional Feature:
- Macro VR_COMMIT_STATS_EN.
- Defined: adds outputs stat_committed (INT_W, +1 per header write) and stat_gaps (32 bits, +1 per GAP completion). Both reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package additions: commit_req struct {view, opnum}; cmt_status enum {CMT_OK, CMT_STALE, CMT_GAP, CMT_RANGE}; commit_done struct {count, status}.
- Reuse the existing log_entry_hdr and LOG_STATE_COMMITED.
- One sub-module: vr_commit_engine_datapath. It holds the latched request, cur, count, last_commit, header rewrite and comparators. The top-level file holds the FSM.

Test Plan:
- Setup last_commit=5; commit view=curr_view=2, opnum=8; RAM entries 6..8 valid -> three writes at addrs 6, 7, 8 with state=0; done count=3, status OK; last_commit=8.
- Commit opnum=4 with last_commit=8 -> no memory traffic; done count=0, status STALE; last_commit unchanged.
- last_commit=1020, commit opnum=1026 -> writes at addrs 1021, 1022, 1023, 0, 1, 2; count=6, status OK.
- Entries 9..10 valid, 11 has op_num=0, commit opnum=12 -> count=2, status GAP, last_commit=10; 11 not written.
- last_commit=0, commit opnum=1025 -> status RANGE, count=0, no reads issued.
- Hold hdr_wr_req_rdy=0 for 5 cycles, then assert rst_n=0 -> outputs return to reset values; already-written entries remain committed; last_commit=0.

Source files
------------

// File: rtl/vr_commit_engine_pkg.sv
// Shared types for the replica commit engine and the log-entry header store.
// Header layout, commit request/completion records and status codes.
// Optional statistics are enabled by defining VR_COMMIT_STATS_EN.
package vr_commit_engine_pkg;

  localparam int INT_W           = 64;
  localparam int LOG_DEPTH_W     = 10;
  localparam int LOG_ENTRY_HDR_W = 320;

  // A walk longer than the log depth would revisit aliased slots.
  localparam logic [INT_W-1:0] LOG_SPAN = 64'd1 << LOG_DEPTH_W;
  localparam logic [INT_W-1:0] INT_ONE  = 64'd1;

  localparam logic [7:0] LOG_STATE_COMMITED = 8'h00;
  localparam logic [7:0] LOG_STATE_PREPARED = 8'h01;

  typedef struct packed {
    logic [INT_W-1:0] view;
    logic [INT_W-1:0] op_num;
    logic [INT_W-1:0] client_id;
    logic [INT_W-1:0] req_num;
    logic [7:0]       log_entry_state;
    logic [55:0]      rsvd;
  } log_entry_hdr;

  typedef struct packed {
    logic [INT_W-1:0] view;
    logic [INT_W-1:0] opnum;
  } commit_req;

  typedef enum logic [1:0] {
    CMT_OK    = 2'd0,
    CMT_STALE = 2'd1,
    CMT_GAP   = 2'd2,
    CMT_RANGE = 2'd3
  } cmt_status;

  typedef struct packed {
    logic [INT_W-1:0] count;
    cmt_status        status;
  } commit_done;

  // Same header with only the state field rewritten to committed.
  function automatic log_entry_hdr commit_hdr(input log_entry_hdr h);
    log_entry_hdr r;
    r = h;
    r.log_entry_state = LOG_STATE_COMMITED;
    return r;
  endfunction

endpackage

// File: rtl/vr_commit_engine_datapath.sv
// Commit engine datapath: latched request, walk pointer, count, last_commit, header rewrite.
// Latency: registers update on the cycle the FSM strobes them; compare outputs are combinational.
// Backpressure: none of its own; strobes only fire on handshakes decided by the FSM.
module vr_commit_engine_datapath
  import vr_commit_engine_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   setup_load,
  input  logic [INT_W-1:0]       setup_last_commit,
  input  logic [INT_W-1:0]       curr_view,
  input  logic                   req_load,
  input  commit_req              req_in,
  input  logic                   walk_start,
  input  logic                   hdr_load,
  input  log_entry_hdr           hdr_in,
  input  logic                   wr_commit,
  input  logic                   cur_advance,
  input  logic                   status_load,
  input  cmt_status              status_in,
  input  logic                   done_clear,
  output logic                   stale,
  output logic                   range_err,
  output logic                   hdr_match,
  output logic                   at_target,
  output logic [LOG_DEPTH_W-1:0] cur_addr,
  output log_entry_hdr           wr_hdr,
  output commit_done             done_rec,
  output logic [INT_W-1:0]       last_commit
);

  commit_req        req_q;
  cmt_status        status_q;
  logic [INT_W-1:0] cur;
  logic [INT_W-1:0] count;
  log_entry_hdr     hdr_q;
  logic [INT_W-1:0] span;

  // Latch the accepted request and the completion status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '0;
      status_q <= CMT_OK;
    end else begin
      if (req_load)    req_q    <= req_in;
      if (status_load) status_q <= status_in;
    end
  end

  // Walk pointer: starts just past last_commit, steps after each write.
  always_ff @(posedge clk) begin
    if (!rst_n)           cur <= '0;
    else if (walk_start)  cur <= last_commit + INT_ONE;
    else if (cur_advance) cur <= cur + INT_ONE;
  end

  // Hold the header read back so the write payload stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n)        hdr_q <= '0;
    else if (hdr_load) hdr_q <= hdr_in;
  end

  // last_commit moves on setup or on each accepted header write; count tracks this request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_commit <= '0;
      count       <= '0;
    end else begin
      if (setup_load)     last_commit <= setup_last_commit;
      else if (wr_commit) last_commit <= cur;
      if (wr_commit)       count <= count + INT_ONE;
      else if (done_clear) count <= '0;
    end
  end

  // Unsigned distance; only meaningful once opnum > last_commit is known.
  assign span      = req_q.opnum - last_commit;
  assign stale     = (req_q.view != curr_view) || (req_q.opnum <= last_commit);
  assign range_err = span > LOG_SPAN;
  // An entry whose op/view do not match has not been prepared yet.
  assign hdr_match = (hdr_in.op_num == cur) && (hdr_in.view == req_q.view);
  assign at_target = (cur == req_q.opnum);
  assign cur_addr  = cur[LOG_DEPTH_W-1:0];
  assign wr_hdr    = commit_hdr(hdr_q);
  assign done_rec  = '{count: count, status: status_q};

endmodule

// File: rtl/vr_commit_engine.sv
// Commit sequencer: walks last_commit+1..opnum, rewrites each header as committed. Stats: VR_COMMIT_STATS_EN.
// Latency: 3N+2 cycles from accept to done for N entries with zero-wait header memory.
// Backpressure: val/rdy on every port; one memory transaction outstanding; request rdy only in IDLE.
module vr_commit_engine
  import vr_commit_engine_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       setup_val,
  input  logic [INT_W-1:0]           setup_last_commit,
  input  logic [INT_W-1:0]           curr_view,
  input  logic                       cmt_req_val,
  input  logic [INT_W-1:0]           cmt_req_view,
  input  logic [INT_W-1:0]           cmt_req_opnum,
  output logic                       cmt_req_rdy,
  output logic                       hdr_rd_req_val,
  output logic [LOG_DEPTH_W-1:0]     hdr_rd_req_addr,
  input  logic                       hdr_rd_req_rdy,
  input  logic                       hdr_rd_resp_val,
  input  logic [LOG_ENTRY_HDR_W-1:0] hdr_rd_resp_data,
  output logic                       hdr_rd_resp_rdy,
  output logic                       hdr_wr_req_val,
  output logic [LOG_DEPTH_W-1:0]     hdr_wr_req_addr,
  output logic [LOG_ENTRY_HDR_W-1:0] hdr_wr_req_data,
  input  logic                       hdr_wr_req_rdy,
  output logic                       cmt_done_val,
  output logic [INT_W-1:0]           cmt_done_count,
  output logic [1:0]                 cmt_done_status,
  input  logic                       cmt_done_rdy,
  output logic [INT_W-1:0]           last_commit
`ifdef VR_COMMIT_STATS_EN
  ,
  output logic [INT_W-1:0]           stat_committed,
  output logic [31:0]                stat_gaps
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_RESP = 3'd3;
  localparam logic [2:0] S_WR      = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]   state, state_nxt;
  logic         req_fire, rd_fire, resp_fire, wr_fire, done_fire;
  logic         walk_start, hdr_load, cur_advance, status_load;
  cmt_status    status_in;
  logic         stale, range_err, hdr_match, at_target;
  logic [LOG_DEPTH_W-1:0] cur_addr;
  log_entry_hdr wr_hdr;
  commit_done   done_rec;

  // Setup wins over a same-cycle request, so the request is simply not accepted.
  assign cmt_req_rdy     = rst_n && (state == S_IDLE) && !setup_val;
  assign hdr_rd_req_val  = rst_n && (state == S_RD_REQ);
  assign hdr_rd_resp_rdy = rst_n && (state == S_RD_RESP);
  assign hdr_wr_req_val  = rst_n && (state == S_WR);
  assign cmt_done_val    = rst_n && (state == S_DONE);

  assign req_fire  = cmt_req_val && cmt_req_rdy;
  assign rd_fire   = hdr_rd_req_val && hdr_rd_req_rdy;
  assign resp_fire = hdr_rd_resp_val && hdr_rd_resp_rdy;
  assign wr_fire   = hdr_wr_req_val && hdr_wr_req_rdy;
  assign done_fire = cmt_done_val && cmt_done_rdy;

  assign hdr_rd_req_addr = cur_addr;
  assign hdr_wr_req_addr = cur_addr;
  assign hdr_wr_req_data = wr_hdr;
  assign cmt_done_count  = done_rec.count;
  assign cmt_done_status = done_rec.status;

  // State register; reset abandons any walk in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt   = state;
    walk_start  = 1'b0;
    hdr_load    = 1'b0;
    cur_advance = 1'b0;
    status_load = 1'b0;
    status_in   = CMT_OK;
    case (state)
      S_IDLE: if (req_fire) state_nxt = S_CHECK;
      S_CHECK: begin
        if (stale) begin
          status_load = 1'b1;
          status_in   = CMT_STALE;
          state_nxt   = S_DONE;
        end else if (range_err) begin
          status_load = 1'b1;
          status_in   = CMT_RANGE;
          state_nxt   = S_DONE;
        end else begin
          walk_start = 1'b1;
          state_nxt  = S_RD_REQ;
        end
      end
      S_RD_REQ: if (rd_fire) state_nxt = S_RD_RESP;
      S_RD_RESP: begin
        if (resp_fire) begin
          if (hdr_match) begin
            hdr_load  = 1'b1;
            state_nxt = S_WR;
          end else begin
            status_load = 1'b1;
            status_in   = CMT_GAP;
            state_nxt   = S_DONE;
          end
        end
      end
      S_WR: begin
        if (wr_fire) begin
          if (at_target) begin
            status_load = 1'b1;
            status_in   = CMT_OK;
            state_nxt   = S_DONE;
          end else begin
            cur_advance = 1'b1;
            state_nxt   = S_RD_REQ;
          end
        end
      end
      S_DONE: if (done_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  vr_commit_engine_datapath u_dp (
    .clk               (clk),
    .rst_n             (rst_n),
    .setup_load        (rst_n && (state == S_IDLE) && setup_val),
    .setup_last_commit (setup_last_commit),
    .curr_view         (curr_view),
    .req_load          (req_fire),
    .req_in            ('{view: cmt_req_view, opnum: cmt_req_opnum}),
    .walk_start        (walk_start),
    .hdr_load          (hdr_load),
    .hdr_in            (log_entry_hdr'(hdr_rd_resp_data)),
    .wr_commit         (wr_fire),
    .cur_advance       (cur_advance),
    .status_load       (status_load),
    .status_in         (status_in),
    .done_clear        (done_fire),
    .stale             (stale),
    .range_err         (range_err),
    .hdr_match         (hdr_match),
    .at_target         (at_target),
    .cur_addr          (cur_addr),
    .wr_hdr            (wr_hdr),
    .done_rec          (done_rec),
    .last_commit       (last_commit)
  );

`ifdef VR_COMMIT_STATS_EN
  // Saturating activity counters: headers written and GAP completions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_committed <= '0;
      stat_gaps      <= '0;
    end else begin
      if (wr_fire && (stat_committed != '1))
        stat_committed <= stat_committed + INT_ONE;
      if (done_fire && (done_rec.status == CMT_GAP) && (stat_gaps != '1))
        stat_gaps <= stat_gaps + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vr_commit_engine.sv
// Scoreboard bench for vr_commit_engine with a behavioural zero-wait header RAM.
// Expected writes/completions are queued by stimulus and checked by a monitor.
// Write backpressure is driven only in the final reset-mid-walk scenario.
module tb_vr_commit_engine;
  import vr_commit_engine_pkg::*;

  typedef struct {
    logic [9:0]   addr;
    log_entry_hdr data;
  } wr_exp_t;

  typedef struct {
    logic [63:0] count;
    logic [1:0]  status;
  } done_exp_t;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       setup_val;
  logic [63:0]                setup_last_commit;
  logic [63:0]                curr_view;
  logic                       cmt_req_val;
  logic [63:0]                cmt_req_view;
  logic [63:0]                cmt_req_opnum;
  logic                       cmt_req_rdy;
  logic                       hdr_rd_req_val;
  logic [9:0]                 hdr_rd_req_addr;
  logic                       hdr_rd_req_rdy;
  logic                       hdr_rd_resp_val;
  logic [319:0]               hdr_rd_resp_data;
  logic                       hdr_rd_resp_rdy;
  logic                       hdr_wr_req_val;
  logic [9:0]                 hdr_wr_req_addr;
  logic [319:0]               hdr_wr_req_data;
  logic                       hdr_wr_req_rdy;
  logic                       cmt_done_val;
  logic [63:0]                cmt_done_count;
  logic [1:0]                 cmt_done_status;
  logic                       cmt_done_rdy;
  logic [63:0]                last_commit;

  log_entry_hdr mem [0:1023];
  wr_exp_t      exp_wr[$];
  done_exp_t    exp_done[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  int           rd_cnt = 0;

  always #5 clk = ~clk;

  vr_commit_engine dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .setup_val         (setup_val),
    .setup_last_commit (setup_last_commit),
    .curr_view         (curr_view),
    .cmt_req_val       (cmt_req_val),
    .cmt_req_view      (cmt_req_view),
    .cmt_req_opnum     (cmt_req_opnum),
    .cmt_req_rdy       (cmt_req_rdy),
    .hdr_rd_req_val    (hdr_rd_req_val),
    .hdr_rd_req_addr   (hdr_rd_req_addr),
    .hdr_rd_req_rdy    (hdr_rd_req_rdy),
    .hdr_rd_resp_val   (hdr_rd_resp_val),
    .hdr_rd_resp_data  (hdr_rd_resp_data),
    .hdr_rd_resp_rdy   (hdr_rd_resp_rdy),
    .hdr_wr_req_val    (hdr_wr_req_val),
    .hdr_wr_req_addr   (hdr_wr_req_addr),
    .hdr_wr_req_data   (hdr_wr_req_data),
    .hdr_wr_req_rdy    (hdr_wr_req_rdy),
    .cmt_done_val      (cmt_done_val),
    .cmt_done_count    (cmt_done_count),
    .cmt_done_status   (cmt_done_status),
    .cmt_done_rdy      (cmt_done_rdy),
    .last_commit       (last_commit)
  );

  function automatic log_entry_hdr mk_hdr(input logic [63:0] op, input logic [63:0] v,
                                          input logic [7:0] st);
    log_entry_hdr h;
    h.view            = v;
    h.op_num          = op;
    h.client_id       = op * 64'd3 + 64'd7;
    h.req_num         = {op[31:0], 32'hA5A5_0000};
    h.log_entry_state = st;
    h.rsvd            = 56'h01_2345_6789_ABCD;
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [63:0] op, input logic [63:0] v);
    wr_exp_t e;
    e.addr = op[9:0];
    e.data = mk_hdr(op, v, 8'h00);
    exp_wr.push_back(e);
  endtask

  task automatic push_done(input logic [63:0] cnt, input logic [1:0] st);
    done_exp_t e;
    e.count  = cnt;
    e.status = st;
    exp_done.push_back(e);
  endtask

  // Zero-wait header RAM: response the cycle after the read is accepted.
  always @(posedge clk) begin
    if (!rst_n) begin
      hdr_rd_resp_val <= 1'b0;
    end else begin
      if (hdr_rd_resp_val && hdr_rd_resp_rdy) hdr_rd_resp_val <= 1'b0;
      if (hdr_rd_req_val && hdr_rd_req_rdy) begin
        hdr_rd_resp_val  <= 1'b1;
        hdr_rd_resp_data <= mem[hdr_rd_req_addr];
      end
      if (hdr_wr_req_val && hdr_wr_req_rdy) mem[hdr_wr_req_addr] <= hdr_wr_req_data;
    end
  end

  // Monitor: checks every write and completion handshake against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (hdr_rd_req_val && hdr_rd_req_rdy) rd_cnt++;
      if (hdr_wr_req_val && hdr_wr_req_rdy) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: addr %0d, expected no write", hdr_wr_req_addr);
        end else begin
          wr_exp_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 64'(hdr_wr_req_addr), 64'(e.addr));
          n_cmp++;
          if (hdr_wr_req_data !== e.data) begin
            n_fail++;
            $display("FAIL wr_data: got %h, expected %h", hdr_wr_req_data, e.data);
          end
        end
      end
      if (cmt_done_val && cmt_done_rdy) begin
        if (exp_done.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: count %0d status %0d", cmt_done_count, cmt_done_status);
        end else begin
          done_exp_t d;
          d = exp_done.pop_front();
          chk("done_count", cmt_done_count, d.count);
          chk("done_status", 64'(cmt_done_status), 64'(d.status));
        end
      end
    end
  end

  task automatic do_setup(input logic [63:0] lc);
    @(negedge clk);
    setup_val = 1'b1;
    setup_last_commit = lc;
    @(negedge clk);
    setup_val = 1'b0;
  endtask

  task automatic run_commit(input logic [63:0] v, input logic [63:0] op, input int exp_lat,
                            input int exp_reads, input logic [63:0] exp_lc);
    int cyc;
    int rd0;
    rd0 = rd_cnt;
    @(negedge clk);
    cmt_req_view  = v;
    cmt_req_opnum = op;
    cmt_req_val   = 1'b1;
    cyc = 0;
    while (!cmt_req_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    cmt_req_val = 1'b0;
    cyc = 1;
    while (!cmt_done_val && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'(exp_lat));
    @(negedge clk);
    chk("read_count", 64'(rd_cnt - rd0), 64'(exp_reads));
    chk("last_commit", last_commit, exp_lc);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst_n = 1'b0; setup_val = 1'b0; setup_last_commit = '0; curr_view = 64'd2;
    cmt_req_val = 1'b0; cmt_req_view = '0; cmt_req_opnum = '0;
    hdr_rd_req_rdy = 1'b1; hdr_wr_req_rdy = 1'b1; cmt_done_rdy = 1'b1;
    hdr_rd_resp_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", 64'(cmt_req_rdy), 64'd0);
    chk("rst_rd_val", 64'(hdr_rd_req_val), 64'd0);
    chk("rst_wr_val", 64'(hdr_wr_req_val), 64'd0);
    chk("rst_done_val", 64'(cmt_done_val), 64'd0);
    chk("rst_last_commit", last_commit, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_rdy", 64'(cmt_req_rdy), 64'd1);

    // Three-entry OK walk: 3*3+2 cycles.
    for (int op = 6; op <= 8; op++) mem[op] = mk_hdr(64'(op), 64'd2, LOG_STATE_PREPARED);
    do_setup(64'd5);
    chk("setup_last_commit", last_commit, 64'd5);
    for (int op = 6; op <= 8; op++) push_wr(64'(op), 64'd2);
    push_done(64'd3, 2'd0);
    run_commit(64'd2, 64'd8, 11, 3, 64'd8);

    // Stale opnum: no memory traffic.
    push_done(64'd0, 2'd1);
    run_commit(64'd2, 64'd4, 2, 0, 64'd8);

    // Stale view.
    push_done(64'd0, 2'd1);
    run_commit(64'd3, 64'd9, 2, 0, 64'd8);

    // Gap at 11 after committing 9 and 10.
    for (int op = 9; op <= 10; op++) mem[op] = mk_hdr(64'(op), 64'd2, LOG_STATE_PREPARED);
    for (int op = 9; op <= 10; op++) push_wr(64'(op), 64'd2);
    push_done(64'd2, 2'd2);
    run_commit(64'd2, 64'd12, 10, 3, 64'd10);
    chk("gap_entry_untouched", 64'(mem[11].op_num), 64'd0);

    // Address wrap 1021..1026 -> slots 1021,1022,1023,0,1,2.
    for (int op = 1021; op <= 1026; op++) mem[op % 1024] = mk_hdr(64'(op), 64'd2, LOG_STATE_PREPARED);
    do_setup(64'd1020);
    for (int op = 1021; op <= 1026; op++) push_wr(64'(op), 64'd2);
    push_done(64'd6, 2'd0);
    run_commit(64'd2, 64'd1026, 20, 6, 64'd1026);

    // Distance exactly the log depth is allowed: walk starts, slot 1 holds op 1025 -> GAP.
    do_setup(64'd0);
    push_done(64'd0, 2'd2);
    run_commit(64'd2, 64'd1024, 4, 1, 64'd0);

    // One past the log depth: RANGE, no reads.
    push_done(64'd0, 2'd3);
    run_commit(64'd2, 64'd1025, 2, 0, 64'd0);

    // Reset mid-walk while a write is held off.
    mem[21] = mk_hdr(64'd21, 64'd2, LOG_STATE_PREPARED);
    mem[22] = mk_hdr(64'd22, 64'd2, LOG_STATE_PREPARED);
    do_setup(64'd20);
    push_wr(64'd21, 64'd2);
    @(negedge clk);
    cmt_req_view = 64'd2; cmt_req_opnum = 64'd22; cmt_req_val = 1'b1;
    @(negedge clk);
    cmt_req_val = 1'b0;
    cyc = 0;
    while (!hdr_wr_req_val && cyc < 50) begin @(negedge clk); cyc++; end
    chk("first_wr_seen", 64'(hdr_wr_req_val), 64'd1);
    @(negedge clk);
    hdr_wr_req_rdy = 1'b0;
    cyc = 0;
    while (!hdr_wr_req_val && cyc < 50) begin @(negedge clk); cyc++; end
    for (int i = 0; i < 5; i++) begin
      chk("held_wr_val", 64'(hdr_wr_req_val), 64'd1);
      chk("held_wr_addr", 64'(hdr_wr_req_addr), 64'd22);
      if (i < 4) @(negedge clk);
    end
    chk("mid_walk_last_commit", last_commit, 64'd21);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_val", 64'(hdr_wr_req_val), 64'd0);
    chk("mid_rst_rd_val", 64'(hdr_rd_req_val), 64'd0);
    chk("mid_rst_resp_rdy", 64'(hdr_rd_resp_rdy), 64'd0);
    chk("mid_rst_done_val", 64'(cmt_done_val), 64'd0);
    chk("mid_rst_req_rdy", 64'(cmt_req_rdy), 64'd0);
    chk("mid_rst_last_commit", last_commit, 64'd0);
    chk("entry21_committed", 64'(mem[21].log_entry_state), 64'd0);
    chk("entry22_not_committed", 64'(mem[22].log_entry_state), 64'(LOG_STATE_PREPARED));
    rst_n = 1'b1;
    hdr_wr_req_rdy = 1'b1;
    @(negedge clk);
    chk("post_rst_req_rdy", 64'(cmt_req_rdy), 64'd1);
    repeat (3) @(negedge clk);
    chk("post_rst_no_write", 64'(hdr_wr_req_val), 64'd0);

    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
